boolexp_stim_gen: RTL and testbench
===================================

# boolexp_stim_gen

- Self-contained stimulus and capture stage that sits directly upstream of a 3-input combinational boolean block.
- Sequences `{a,b,c}` through all 8 input combinations in ascending order (000 to 111) and holds each for a programmable number of cycles.
- Samples the block's `y` output at the end of each hold and reports the 8-entry captured truth table, with an optional compare against an expected table.
- Replaces hand-written delay-based stimulus with a synthesizable, on-board-testable sequencer.

## Interface
Parameters:
- `HOLD_CYCLES`, default 10: cycles each input combination is held. Legal range is 2..255.
- `EXPECTED`, default 8'hE8: expected truth table. Bit i is the expected `y` for `{a,b,c}` == i.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a sweep when sampled high in IDLE.
- `y`  in  1  output of the downstream boolean block.
- `a`  out  1  MSB of the current input combination.
- `b`  out  1  middle bit of the current input combination.
- `c`  out  1  LSB of the current input combination.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `result`  out  8  captured truth table; bit i is `y` sampled for index i.
- `mismatch`  out  8  `result ^ EXPECTED`. Valid from `done` onward.
- `pass`  out  1  high when `mismatch == 0`. Valid from `done` until the next `start` or reset.

## Operation
- States: IDLE, RUN, DONE.
- Registers:
  - 3-bit index `idx`.
  - 8-bit hold counter `hcnt`.
  - 8-bit `result`.
- `{a,b,c}` are driven directly from `idx` (registered outputs).

IDLE:
- `busy`=0, `{a,b,c}`=000.
- `start`=1 moves to RUN with `idx`=0 and `hcnt`=0, and clears `result`, `mismatch` and `pass`.

RUN:
- `busy`=1.
- `hcnt` increments every cycle.
- When `hcnt`==HOLD_CYCLES-1:
  - `result[idx]` is loaded with `y`.
  - `hcnt` returns to 0.
  - If `idx`==7, go to DONE; otherwise `idx` increments.
- `start` is ignored in RUN.

DONE:
- Lasts exactly one cycle, with `done`=1 and `busy`=0.
- `{a,b,c}` return to 000 on entry.
- Always transitions to IDLE.
- `start` is ignored in DONE.

General rules:
- `result`, `mismatch` and `pass` hold their values in IDLE until the next `start`.
- `idx` does not wrap during a sweep; the sweep ends at index 7.

## Timing
- Reset values of all outputs:
  - `a`,`b`,`c`,`busy`,`done`,`pass` = 0.
  - `result` = 8'h00.
  - `mismatch` = 8'h00.
- Reset clears the state to IDLE.
- Reset takes effect immediately, including mid-sweep. No partial result survives, and `start` is ignored while `rst` is high.
- Let edge E0 be the edge that samples `start`=1 in IDLE.
  - `busy` rises after E0.
  - `{a,b,c}`=000 for cycles 1..HOLD_CYCLES after E0.
- Combination i is presented for exactly HOLD_CYCLES cycles.
- `y` for combination i is sampled on the edge ending the last of those cycles. This gives the downstream block HOLD_CYCLES-1 full cycles to settle.
- Each new combination appears on the same edge that samples the previous one.
- Total sweep is 8×HOLD_CYCLES cycles. `done` is high in cycle 8×HOLD_CYCLES+1 after E0.
- `mismatch` and `pass` update on the same edge that raises `done`.
- A `start` held continuously re-triggers on the first IDLE cycle after DONE. Back-to-back sweeps are separated by one IDLE cycle.

## Configuration
Macro: `BOOLEXP_STIM_CHECK_EN`.

- **Defined:** the compare logic is built. `mismatch` = `result ^ EXPECTED`, and `pass` = (`mismatch` == 0), both registered at DONE.
- **Not defined:** the compare logic is omitted and `EXPECTED` is unused.
  - `mismatch` is tied to 8'h00.
  - `pass` is tied to 0.
  - `result` and all other behaviour are unchanged.

## Test plan
1. Reset mid-sweep: assert `rst` in RUN at `idx`=4 → all outputs 0 in the same cycle; after release, state is IDLE and `{a,b,c}`=000.
2. Majority model (`y` = ab|bc|ac), HOLD_CYCLES=10, pulse `start` → combinations 000..111 each held 10 cycles, `done` at cycle 81, `result`=8'hE8, `mismatch`=0, `pass`=1.
3. XOR model (`y` = a^b^c), EXPECTED=8'hE8 → `result`=8'h96, `mismatch`=8'h7E, `pass`=0. Without `BOOLEXP_STIM_CHECK_EN`: `mismatch`=0, `pass`=0, `result`=8'h96.
4. Settling: `y` model with a 1-cycle registered delay, HOLD_CYCLES=2 → still captures the correct table (8'hE8 for the majority model).
5. `start` pulsed at sweep cycles 3 and 40 → ignored; exactly one `done` and a correct `result`.
6. `start` held high through two sweeps → `done` at cycle 81, IDLE for one cycle, second sweep begins, second `done` at cycle 163, identical `result`.

Source files
------------

// File: rtl/boolexp_stim_gen.sv
// boolexp_stim_gen: sweeps {a,b,c} through 000..111, holding each combination HOLD_CYCLES cycles, and captures y.
// Optional compare against EXPECTED is built when BOOLEXP_STIM_CHECK_EN is defined.
module boolexp_stim_gen #(
    parameter int         HOLD_CYCLES = 10,
    parameter logic [7:0] EXPECTED    = 8'hE8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [7:0] mismatch,
    output logic       pass
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     state;
    logic [2:0] idx;
    logic [7:0] hcnt;
    logic       last;
    logic       final_hold;
    logic [7:0] result_nxt;
    assign last       = hcnt == 8'(HOLD_CYCLES - 1);
    assign final_hold = state == RUN && last && idx == 3'd7;
    assign {a, b, c}  = idx;
    always_comb begin
        result_nxt      = result;
        result_nxt[idx] = y;
    end
    // idx is forced to 0 outside RUN so the outputs read 000 in IDLE and DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= 3'd0;
            hcnt   <= 8'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        idx    <= 3'd0;
                        hcnt   <= 8'd0;
                        result <= 8'h00;
                    end
                end
                RUN: begin
                    hcnt <= last ? 8'd0 : hcnt + 8'd1;
                    if (last) begin
                        result <= result_nxt;
                        idx    <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    idx   <= 3'd0;
                end
            endcase
        end
    end
`ifdef BOOLEXP_STIM_CHECK_EN
    // Compare uses the table including the bit captured on the final edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch <= 8'h00;
            pass     <= 1'b0;
        end else if (state == IDLE && start) begin
            mismatch <= 8'h00;
            pass     <= 1'b0;
        end else if (final_hold) begin
            mismatch <= result_nxt ^ EXPECTED;
            pass     <= result_nxt == EXPECTED;
        end
    end
`else
    logic unused_check;
    assign unused_check = ^{EXPECTED, final_hold};
    assign mismatch     = 8'h00;
    assign pass         = 1'b0;
`endif
endmodule

// File: tb/tb_boolexp_stim_gen.sv
// tb_boolexp_stim_gen: table-driven sweeps over several y models plus reset, settling and start-handling sequences.
module tb_boolexp_stim_gen;
    logic       clk = 1'b0;
    logic       rst, start, y, a, b, c, busy, done, pass;
    logic [7:0] result, mismatch;
    logic       start2, y2, a2, b2, c2, busy2, done2, pass2;
    logic [7:0] result2, mismatch2;
    int         mode;
    int         tests = 0;
    int         fails = 0;
`ifdef BOOLEXP_STIM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    boolexp_stim_gen #(.HOLD_CYCLES(10), .EXPECTED(8'hE8)) dut (
        .clk(clk), .rst(rst), .start(start), .y(y), .a(a), .b(b), .c(c),
        .busy(busy), .done(done), .result(result), .mismatch(mismatch), .pass(pass)
    );

    boolexp_stim_gen #(.HOLD_CYCLES(2), .EXPECTED(8'hE8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .y(y2), .a(a2), .b(b2), .c(c2),
        .busy(busy2), .done(done2), .result(result2), .mismatch(mismatch2), .pass(pass2)
    );

    always_comb begin
        y = 1'b0;
        case (mode)
            0: y = (a & b) | (b & c) | (a & c);
            1: y = a ^ b ^ c;
            2: y = a;
            3: y = 1'b0;
            4: y = c;
            default: y = 1'b0;
        endcase
    end

    // one-cycle registered settling delay
    always_ff @(posedge clk) y2 <= (a2 & b2) | (b2 & c2) | (a2 & c2);

    typedef struct {
        int         mode;
        logic [7:0] res;
        logic [7:0] mm;
        bit         pas;
        bit         extra;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sweep(input bit extra, output int dcyc, output int seq_err);
        dcyc    = 0;
        seq_err = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 200 && dcyc == 0; cyc++) begin
            @(negedge clk);
            start = extra && (cyc == 3 || cyc == 40);
            if (done) dcyc = cyc;
            else if (!busy || {a, b, c} != 3'((cyc - 1) / 10)) seq_err++;
        end
        start = 1'b0;
    endtask

    initial begin
        int dcyc, serr, ndone, d1, d2, busy82, busy83;
        logic [7:0] r1, r2;
        vecs[0] = '{0, 8'hE8, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1, 8'h96, 8'h7E, 1'b0, 1'b0};
        vecs[2] = '{2, 8'hF0, 8'h18, 1'b0, 1'b0};
        vecs[3] = '{3, 8'h00, 8'hE8, 1'b0, 1'b0};
        vecs[4] = '{4, 8'hAA, 8'h42, 1'b0, 1'b0};
        vecs[5] = '{0, 8'hE8, 8'h00, 1'b1, 1'b1};
        rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 0;
        repeat (2) @(negedge clk);
        check("reset_state", {a, b, c, busy, done, pass, result, mismatch}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            mode = vecs[i].mode;
            sweep(vecs[i].extra, dcyc, serr);
            check($sformatf("v%0d_done_cycle", i), dcyc, 81);
            check($sformatf("v%0d_sequence", i), serr, 0);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_mismatch", i), mismatch, CHK ? vecs[i].mm : 8'h00);
            check($sformatf("v%0d_pass", i), pass, CHK ? vecs[i].pas : 1'b0);
            ndone = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                ndone += (done || busy) ? 1 : 0;
            end
            check($sformatf("v%0d_idle_after", i), ndone, 0);
            check($sformatf("v%0d_hold_result", i), result, vecs[i].res);
        end

        // reset in the middle of the sweep while idx==4
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_abc", {a, b, c}, 3'b100);
        check("pre_reset_result", result, 8'h08);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", {a, b, c, busy, done, pass, result, mismatch}, 0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_idle", {a, b, c, busy, done}, 0);

        // start held through two back-to-back sweeps
        d1 = 0; d2 = 0; busy82 = 0; busy83 = 0; r1 = 0; r2 = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 250 && d2 == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 82) busy82 = int'(busy);
            if (cyc == 83) busy83 = int'(busy);
            if (done && d1 == 0) begin d1 = cyc; r1 = result; end
            else if (done) begin d2 = cyc; r2 = result; end
        end
        start = 1'b0;
        check("held_done1", d1, 81);
        check("held_idle_gap", busy82, 0);
        check("held_restart", busy83, 1);
        check("held_done2", d2, 163);
        check("held_result1", r1, 8'hE8);
        check("held_result2", r2, 8'hE8);

        // settling with HOLD_CYCLES=2 and a registered y
        dcyc = 0;
        @(negedge clk);
        start2 = 1'b1;
        for (int cyc = 1; cyc <= 60 && dcyc == 0; cyc++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (done2) dcyc = cyc;
        end
        check("settle_done_cycle", dcyc, 17);
        check("settle_result", result2, 8'hE8);
        check("settle_pass", pass2, CHK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
